// File: rtl/vga_defs.sv
// vga_defs: shared VGA timing, framebuffer geometry and display-FSM state encodings
// Contents:
//   H_TOTAL/V_TOTAL   full line/frame counts (800/525)
//   H_ACT/V_ACT       visible area (640/480)
//   FB_W/FB_H         framebuffer words per line / lines
//   SCALE_SHIFT       log2 of the screen-pixel block edge covered by one fb word
//   dstate_t          display FSM states D_IDLE/D_RD/D_CAP
package vga_defs;
    localparam int H_TOTAL     = 800;
    localparam int V_TOTAL     = 525;
    localparam int H_ACT       = 640;
    localparam int V_ACT       = 480;
    localparam int SCALE_SHIFT = 2;
    localparam int FB_W        = H_ACT >> SCALE_SHIFT;
    localparam int FB_H        = V_ACT >> SCALE_SHIFT;
    typedef enum logic [1:0] {D_IDLE = 2'd0, D_RD = 2'd1, D_CAP = 2'd2} dstate_t;
endpackage

// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: posted host write bus into the framebuffer arbiter
// Signals:
//   host_valid/host_ready   write handshake, transfer when both high at clk
//   host_addr/host_data     framebuffer word address and pixel data
//   wr_drop                 1-clk pulse when an accepted write was out of range
// Modports: master = host writer, slave = arbiter
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 15
);
    logic              host_valid;
    logic              host_ready;
    logic [ADDR_W-1:0] host_addr;
    logic [15:0]       host_data;
    logic              wr_drop;
    modport master (output host_valid, host_addr, host_data, input host_ready, wr_drop);
    modport slave (input host_valid, host_addr, host_data, output host_ready, wr_drop);
endinterface

// File: rtl/vga_wr_fifo.sv
// vga_wr_fifo: synchronous FIFO for posted host writes
// Ports:
//   clk, rst      clock, async active-high reset (empties the FIFO)
//   push, din     write request and data; ignored when full
//   pop, dout     read request; dout shows the head entry combinationally
//   full, empty   occupancy flags
module vga_wr_fifo #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty = wp == rp;
    assign dout  = mem[rp[AW-1:0]];
    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[AW-1:0]] <= din;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer SRAM between VGA scan-out (absolute priority)
//   and a posted host write FIFO that drains in every clk the display does not own.
// Build option: VGA_FB_DOUBLE_BUF_EN enables front/back double buffering with swap at vertical blanking.
// Ports:
//   clk, rst             system clock, async active-high reset
//   pix_en               pixel-clock enable; PixelCount/LineCount give the current scan position
//   color                registered prefetched pixel for the signal generator
//   host (slave)         host write bus: host_valid/host_ready/host_addr/host_data, wr_drop
//   swap_req/swap_done   buffer swap request and 1-clk completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   SRAM port, mem_addr MSB = buffer select
module vga_fb_arbiter
    import vga_defs::*;
#(
    parameter int ADDR_W     = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pix_en,
    input  logic [9:0]      PixelCount,
    input  logic [9:0]      LineCount,
    output logic [15:0]     color,
    vga_fb_arbiter_if.slave host,
    input  logic            swap_req,
    output logic            swap_done,
    output logic            mem_en,
    output logic            mem_we,
    output logic [ADDR_W:0] mem_addr,
    output logic [15:0]     mem_wdata,
    input  logic [15:0]     mem_rdata
);
    localparam int FB_WORDS = FB_W * FB_H;
    dstate_t state;
    logic rd_act, act_n, front, back, pop, empty, full, oob, rd, wr;
    logic [ADDR_W:0] rd_addr;
    logic [9:0] tx, ty;
    logic [ADDR_W-1:0] row, rd_addr_n;
    logic [ADDR_W+15:0] head;
    // prefetch target is the pixel after the current one, wrapping at line and frame end
    always_comb begin
        tx = (PixelCount == 10'(H_TOTAL - 1)) ? 10'd0 : PixelCount + 10'd1;
        ty = (PixelCount != 10'(H_TOTAL - 1)) ? LineCount :
             (LineCount == 10'(V_TOTAL - 1)) ? 10'd0 : LineCount + 10'd1;
        act_n = (tx < 10'(H_ACT)) && (ty < 10'(V_ACT));
        row = ADDR_W'(ty >> SCALE_SHIFT);
        rd_addr_n = (row << 7) + (row << 5) + ADDR_W'(tx >> SCALE_SHIFT);
    end
    vga_wr_fifo #(
        .WIDTH(ADDR_W + 16),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (host.host_valid),
        .pop  (pop),
        .din  ({host.host_addr, host.host_data}),
        .dout (head),
        .full (full),
        .empty(empty)
    );
    // the display owns the SRAM only in D_RD; every other clk retires one host entry
    assign pop = (state != D_RD) && !empty;
    assign oob = head[ADDR_W+15:16] >= ADDR_W'(FB_WORDS);
    assign rd  = (state == D_RD) && rd_act;
    assign wr  = pop && !oob;
    assign mem_en    = rd || wr;
    assign mem_we    = wr;
    assign mem_addr  = rd ? rd_addr : wr ? {back, head[ADDR_W+15:16]} : '0;
    assign mem_wdata = wr ? head[15:0] : 16'h0;
    assign host.host_ready = !full;
    assign host.wr_drop    = pop && oob;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= D_IDLE;
            rd_act  <= 1'b0;
            rd_addr <= '0;
            color   <= 16'h0;
        end else if (state == D_IDLE && pix_en) begin
            state   <= D_RD;
            rd_act  <= act_n;
            rd_addr <= {front, rd_addr_n};
        end else if (state == D_RD) begin
            state <= D_CAP;
        end else if (state == D_CAP) begin
            state <= D_IDLE;
            color <= rd_act ? mem_rdata : 16'h0;
        end
    end
`ifdef VGA_FB_DOUBLE_BUF_EN
    logic swap_pend, swap_now;
    // swapping on the first blanked line means a displayed frame never mixes buffers
    assign swap_now = pix_en && (state == D_IDLE) && (PixelCount == 10'd0) &&
                      (LineCount == 10'(V_ACT)) && swap_pend;
    assign back = !front;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            swap_pend <= 1'b0;
            front     <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            swap_pend <= (swap_pend && !swap_now) || swap_req;
            front     <= front ^ swap_now;
            swap_done <= swap_now;
        end
    end
`else
    logic unused_swap;
    assign unused_swap = swap_req;
    assign front       = 1'b0;
    assign back        = 1'b0;
    assign swap_done   = 1'b0;
`endif
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed self-checking bench for vga_fb_arbiter with a behavioural SRAM
module tb_vga_fb_arbiter;
    logic clk = 1'b0, rst = 1'b1, pix_en = 1'b0, swap_req = 1'b0;
    logic [9:0] PixelCount = 10'd0, LineCount = 10'd0;
    logic [15:0] color, mem_wdata, mem_addr;
    logic [15:0] mem_rdata = 16'h0;
    logic swap_done, mem_en, mem_we;
    logic [15:0] sram [65536];
    logic pl_en = 1'b0;
    logic [15:0] pl_addr = 16'h0, pl_data = 16'h0;
    int tests = 0, fails = 0, since = 10;
`ifdef VGA_FB_DOUBLE_BUF_EN
    localparam logic BK = 1'b1;
`else
    localparam logic BK = 1'b0;
`endif
    vga_fb_arbiter_if #(.ADDR_W(15)) hif ();
    vga_fb_arbiter dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .PixelCount(PixelCount), .LineCount(LineCount),
        .color(color), .host(hif), .swap_req(swap_req), .swap_done(swap_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (pl_en) sram[pl_addr] <= pl_data;
        else if (mem_en && mem_we) sram[mem_addr] <= mem_wdata;
        else if (mem_en) mem_rdata <= sram[mem_addr];
    end
    always @(posedge clk) begin
        if (pix_en && since < 2) $error("pix_en issued while display FSM busy");
        since <= pix_en ? 0 : since + 1;
    end
    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pl_addr = a; pl_data = d; pl_en = 1'b1;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask
    task automatic do_pix(input logic [9:0] p, input logic [9:0] l, output logic en, output logic we,
                          output logic [15:0] addr, output logic [15:0] early, output logic [15:0] col);
        PixelCount = p; LineCount = l; pix_en = 1'b1;
        @(posedge clk); #1;
        pix_en = 1'b0; en = mem_en; we = mem_we; addr = mem_addr;
        @(posedge clk); #1;
        early = color;
        @(posedge clk); #1;
        col = color;
    endtask
    task automatic test_power_on;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        tests++;
        if ({color, mem_en, mem_we, mem_addr, mem_wdata, hif.wr_drop, swap_done} !== '0 || hif.host_ready !== 1'b1) begin
            fails++;
            $display("FAIL power_on: color=%h en=%b we=%b addr=%h ready=%b, want all 0 and ready=1", color, mem_en, mem_we, mem_addr, hif.host_ready);
        end
        @(posedge clk); #1;
    endtask
    task automatic test_fetch;
        logic [9:0] tp [4] = '{10'd799, 10'd3, 10'd399, 10'd638};
        logic [9:0] tl [4] = '{10'd524, 10'd0, 10'd37, 10'd479};
        logic [15:0] ta [4] = '{16'd0, 16'd1, 16'd1540, 16'd19199};
        logic [15:0] tc [4] = '{16'hF800, 16'h07E0, 16'h1234, 16'hABCD};
        logic en, we;
        logic [15:0] a, e, c, prev;
        for (int i = 0; i < 4; i++) preload(ta[i], tc[i]);
        prev = 16'h0;
        for (int i = 0; i < 4; i++) begin
            do_pix(tp[i], tl[i], en, we, a, e, c);
            tests += 4;
            if (en !== 1'b1 || we !== 1'b0) begin
                fails++; $display("FAIL fetch_rd[%0d]: en=%b we=%b want en=1 we=0", i, en, we);
            end
            if (a !== ta[i]) begin
                fails++; $display("FAIL fetch_addr[%0d]: got %h want %h", i, a, ta[i]);
            end
            if (e !== prev) begin
                fails++; $display("FAIL fetch_early[%0d]: color at +2 got %h want %h", i, e, prev);
            end
            if (c !== tc[i]) begin
                fails++; $display("FAIL fetch_color[%0d]: got %h want %h", i, c, tc[i]);
            end
            prev = tc[i];
        end
    endtask
    task automatic test_reset;
        logic bad_we;
        preload({BK, 15'd602}, 16'h0);
        LineCount = 10'd200;
        hif.host_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            hif.host_addr = 15'(600 + i); hif.host_data = 16'(i + 1);
            @(posedge clk); #1;
        end
        rst = 1'b1; hif.host_valid = 1'b0;
        #1;
        tests++;
        if ({color, mem_en, mem_we, mem_addr, mem_wdata, hif.wr_drop, swap_done} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: color=%h en=%b we=%b addr=%h wdata=%h drop=%b swap=%b want all 0", color, mem_en, mem_we, mem_addr, mem_wdata, hif.wr_drop, swap_done);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bad_we = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            bad_we |= mem_we;
        end
        tests += 4;
        if (bad_we !== 1'b0) begin
            fails++; $display("FAIL reset_stale_we: got mem_we=%b want 0", bad_we);
        end
        if (hif.host_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready: got %b want 1", hif.host_ready);
        end
        if (sram[{BK, 15'd602}] !== 16'h0) begin
            fails++; $display("FAIL reset_stale_data: got %h want 0000", sram[{BK, 15'd602}]);
        end
        if (sram[{BK, 15'd600}] !== 16'h0001) begin
            fails++; $display("FAIL reset_pre_write: got %h want 0001", sram[{BK, 15'd600}]);
        end
    endtask
    task automatic test_blank;
        logic [9:0] tp [4] = '{10'd700, 10'd10, 10'd799, 10'd639};
        logic [9:0] tl [4] = '{10'd10, 10'd490, 10'd479, 10'd5};
        logic en, we;
        logic [15:0] a, e, c;
        do_pix(10'd3, 10'd0, en, we, a, e, c);
        tests++;
        if (c !== 16'h07E0) begin
            fails++; $display("FAIL blank_pre: got %h want 07E0", c);
        end
        for (int i = 0; i < 4; i++) begin
            do_pix(tp[i], tl[i], en, we, a, e, c);
            tests += 2;
            if (en !== 1'b0) begin
                fails++; $display("FAIL blank_en[%0d]: got %b want 0", i, en);
            end
            if (c !== 16'h0) begin
                fails++; $display("FAIL blank_color[%0d]: got %h want 0000", i, c);
            end
            if (i == 0) begin
                tests++;
                if (e !== 16'h07E0) begin
                    fails++; $display("FAIL blank_hold: got %h want 07E0", e);
                end
            end
        end
    endtask
    task automatic test_contention;
        logic [30:0] q [$];
        logic [30:0] h;
        int idx = 0, occ = 0;
        logic acc, saw_full = 1'b0;
        LineCount = 10'd50;
        for (int c = 0; c < 80; c++) begin
            pix_en = (c % 4 == 0) && (c < 64);
            PixelCount = 10'(100 + c / 4);
            if (c > 0 && (c - 1) % 4 == 0 && c - 1 < 64) begin
                tests++;
                if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== {1'b0, 15'(1920 + (101 + (c - 1) / 4) / 4)}) begin
                    fails++;
                    $display("FAIL rd_slot[%0d]: en=%b we=%b addr=%h want en=1 we=0 addr=%h", c, mem_en, mem_we, mem_addr, {1'b0, 15'(1920 + (101 + (c - 1) / 4) / 4)});
                end
            end
            tests++;
            if (hif.host_ready !== (occ < 4)) begin
                fails++; $display("FAIL ready[%0d]: got %b want %b (queued %0d)", c, hif.host_ready, occ < 4, occ);
            end
            if (occ == 4) saw_full = 1'b1;
            acc = (idx < 20) && (occ < 4);
            hif.host_valid = idx < 20;
            hif.host_addr = 15'(2000 + idx);
            hif.host_data = 16'(16'hA000 + idx);
            if (mem_we) begin
                tests++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL wr_order[%0d]: got write %h=%h want none", c, mem_addr, mem_wdata);
                end else begin
                    h = q.pop_front();
                    if ({mem_addr, mem_wdata} !== {BK, h}) begin
                        fails++; $display("FAIL wr_order[%0d]: got %h=%h want %h=%h", c, mem_addr, mem_wdata, {BK, h[30:16]}, h[15:0]);
                    end
                end
            end
            occ = occ + (acc ? 1 : 0) - (mem_we ? 1 : 0);
            if (acc) begin
                q.push_back({15'(2000 + idx), 16'(16'hA000 + idx)});
                idx++;
            end
            @(posedge clk); #1;
        end
        hif.host_valid = 1'b0; pix_en = 1'b0;
        tests += 3;
        if (idx != 20 || q.size() != 0 || occ != 0) begin
            fails++; $display("FAIL drain: pushed %0d pending %0d queued %0d want 20 0 0", idx, q.size(), occ);
        end
        if (!saw_full) begin
            fails++; $display("FAIL full_seen: got 0 want 1");
        end
        if (sram[{BK, 15'd2000}] !== 16'hA000 || sram[{BK, 15'd2019}] !== 16'hA013) begin
            fails++; $display("FAIL wr_land: got %h %h want A000 A013", sram[{BK, 15'd2000}], sram[{BK, 15'd2019}]);
        end
    endtask
    task automatic test_oob;
        logic [14:0] a [3] = '{15'd19200, 15'd19199, 15'd300};
        logic [15:0] d [3] = '{16'hFFFF, 16'h1111, 16'h5555};
        int drops = 0;
        preload({BK, 15'd19200}, 16'h0);
        for (int c = 0; c < 10; c++) begin
            hif.host_valid = c < 3;
            if (c < 3) begin
                hif.host_addr = a[c]; hif.host_data = d[c];
            end
            if (hif.wr_drop) begin
                drops++;
                tests++;
                if (mem_we !== 1'b0 || c != 1) begin
                    fails++; $display("FAIL drop_cycle: at %0d we=%b want cycle 1 we=0", c, mem_we);
                end
            end
            if (c == 2) begin
                tests++;
                if (mem_we !== 1'b1 || mem_addr !== {BK, 15'd19199}) begin
                    fails++; $display("FAIL oob_next: we=%b addr=%h want 1 %h", mem_we, mem_addr, {BK, 15'd19199});
                end
            end
            @(posedge clk); #1;
        end
        tests += 4;
        if (drops != 1) begin
            fails++; $display("FAIL drop_count: got %0d want 1", drops);
        end
        if (sram[{BK, 15'd19199}] !== 16'h1111) begin
            fails++; $display("FAIL oob_last_word: got %h want 1111", sram[{BK, 15'd19199}]);
        end
        if (sram[{BK, 15'd300}] !== 16'h5555) begin
            fails++; $display("FAIL oob_after: got %h want 5555", sram[{BK, 15'd300}]);
        end
        if (sram[{BK, 15'd19200}] !== 16'h0) begin
            fails++; $display("FAIL oob_written: got %h want 0000", sram[{BK, 15'd19200}]);
        end
    endtask
`ifdef VGA_FB_DOUBLE_BUF_EN
    task automatic test_swap;
        logic en, we;
        logic [15:0] a, e, c;
        LineCount = 10'd100; swap_req = 1'b1;
        @(posedge clk); #1;
        swap_req = 1'b0;
        PixelCount = 10'd0; LineCount = 10'd479; pix_en = 1'b1;
        @(posedge clk); #1;
        pix_en = 1'b0;
        tests++;
        if (swap_done !== 1'b0) begin
            fails++; $display("FAIL swap_early: got %b want 0", swap_done);
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
        LineCount = 10'd480; pix_en = 1'b1;
        @(posedge clk); #1;
        pix_en = 1'b0;
        tests++;
        if (swap_done !== 1'b1) begin
            fails++; $display("FAIL swap_done: got %b want 1", swap_done);
        end
        @(posedge clk); #1;
        tests++;
        if (swap_done !== 1'b0) begin
            fails++; $display("FAIL swap_pulse: got %b want 0", swap_done);
        end
        @(posedge clk); #1;
        do_pix(10'd3, 10'd0, en, we, a, e, c);
        tests++;
        if (a !== 16'h8001) begin
            fails++; $display("FAIL swap_front: got %h want 8001", a);
        end
        hif.host_valid = 1'b1; hif.host_addr = 15'd5; hif.host_data = 16'h7777;
        @(posedge clk); #1;
        hif.host_valid = 1'b0;
        tests++;
        if (mem_we !== 1'b1 || mem_addr !== 16'h0005) begin
            fails++; $display("FAIL swap_back: we=%b addr=%h want 1 0005", mem_we, mem_addr);
        end
    endtask
`endif
    initial begin
        hif.host_valid = 1'b0; hif.host_addr = '0; hif.host_data = '0;
        test_power_on;
        test_fetch;
        test_reset;
        test_blank;
        test_contention;
        test_oob;
`ifdef VGA_FB_DOUBLE_BUF_EN
        test_swap;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
